team_06_volume_ramp: RTL and testbench

//  Multi-channel volume stage with a parametrised sample width and a log gain lookup.

---
 rtl/team_06_audio_pkg.sv | 20 ++
 rtl/team_06_gain_ramp.sv | 49 ++++
 rtl/team_06_volume_ramp.sv | 81 ++++++++
 tb/tb_team_06_volume_ramp.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/team_06_audio_pkg.sv
// Shared audio definitions for the team_06 volume stage: the log volume
// table, the volume index type and an unsigned saturation helper.
package team_06_audio_pkg;

    typedef logic [3:0] vol_idx_t;

    // Log-spaced gain table. The gain has 4 fraction bits, so entry 16 is unity.
    localparam logic [7:0] VOL_LUT [16] = '{
        8'd0,   8'd4,   8'd7,   8'd11,  8'd16,  8'd23,  8'd32,  8'd45,
        8'd64,  8'd90,  8'd128, 8'd180, 8'd200, 8'd220, 8'd240, 8'd255
    };

    // Clamp an unsigned value to the largest number that fits in 'width' bits.
    function automatic logic [63:0] sat_u(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_val;
        max_val = (64'd1 << width) - 64'd1;
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/team_06_gain_ramp.sv
// Holds the applied gain and moves it toward the target once per accepted
// frame. With TEAM06_VOL_RAMP_EN defined the gain moves by at most RAMP_STEP
// per frame; otherwise it jumps straight to the target.
module team_06_gain_ramp #(
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_en,
    input  logic [GAIN_W-1:0] target,
    output logic [GAIN_W-1:0] cur_gain
);

    if (RAMP_STEP < 1 || RAMP_STEP > (2 ** GAIN_W) - 1) begin : g_bad_step
        $error("RAMP_STEP must be within 1..2^GAIN_W-1");
    end

    logic [GAIN_W-1:0] next_gain;

`ifdef TEAM06_VOL_RAMP_EN
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    // Bounded step toward the target; distances are compared before adding or
    // subtracting so the gain lands exactly on the target and never wraps.
    always_comb begin
        next_gain = cur_gain;
        if (cur_gain < target) begin
            if (target - cur_gain > STEP) next_gain = cur_gain + STEP;
            else                          next_gain = target;
        end else if (cur_gain > target) begin
            if (cur_gain - target > STEP) next_gain = cur_gain - STEP;
            else                          next_gain = target;
        end
    end
`else
    // Direct jump: the gain takes the target on the next accepted frame.
    always_comb begin
        next_gain = target;
    end
`endif

    // Gain register: only moves when a frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cur_gain <= '0;
        else if (step_en) cur_gain <= next_gain;
    end

endmodule

// File: rtl/team_06_volume_ramp.sv
// Multi-channel volume stage: each channel of an accepted frame is scaled by
// the shared gain, shifted by FRAC_W and saturated, behind a single-register
// valid/ready pipe. Macro TEAM06_VOL_RAMP_EN selects ramped gain changes
// (defined) or immediate gain changes (undefined).
module team_06_volume_ramp
    import team_06_audio_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CH        = 2,
    parameter int GAIN_W    = 8,
    parameter int FRAC_W    = 4,
    parameter int RAMP_STEP = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           volume,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic [GAIN_W-1:0]    cur_gain
);

    localparam int PROD_W = DATA_W + GAIN_W;

    if (GAIN_W < 8) begin : g_bad_gain_w
        $error("GAIN_W must be at least 8 to hold the volume table");
    end

    logic                 accept;
    logic [GAIN_W-1:0]    target;
    logic [CH*DATA_W-1:0] scaled;
    vol_idx_t             vol_idx;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign vol_idx  = volume;

    // Target gain from the log table, or zero when muted.
    always_comb begin
        target = '0;
        if (enable) target = GAIN_W'(VOL_LUT[vol_idx]);
    end

    team_06_gain_ramp #(
        .GAIN_W    (GAIN_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_gain_ramp (
        .clk      (clk),
        .rst      (rst),
        .step_en  (accept),
        .target   (target),
        .cur_gain (cur_gain)
    );

    // Per-channel scale: full-width product, fixed-point shift, clamp.
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [PROD_W-1:0] product;
        logic [PROD_W-1:0] shifted;
        assign product = PROD_W'(in_data[gi*DATA_W +: DATA_W]) * PROD_W'(cur_gain);
        assign shifted = product >> FRAC_W;
        assign scaled[gi*DATA_W +: DATA_W] = DATA_W'(sat_u(64'(shifted), DATA_W));
    end

    // Output register: load on accept, drop valid once drained, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= scaled;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_team_06_volume_ramp.sv
// Self-checking bench for team_06_volume_ramp (8-bit samples, 2 channels,
// 8-bit gain, 4 fraction bits, step 8). The reference model follows the
// build's TEAM06_VOL_RAMP_EN setting.
module tb_team_06_volume_ramp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  volume = '0;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [7:0]  cur_gain;

    team_06_volume_ramp #(
        .DATA_W(8), .CH(2), .GAIN_W(8), .FRAC_W(4), .RAMP_STEP(8)
    ) dut (
        .clk(clk), .rst(rst), .volume(volume), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cur_gain(cur_gain)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int lut [16] = '{0, 4, 7, 11, 16, 23, 32, 45, 64, 90, 128, 180, 200, 220, 240, 255};

    // Reference model state
    int m_gain  = 0;
    int m_valid = 0;
    int m_d0    = 0;
    int m_d1    = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int scale(input int d, input int g);
        int v;
        v = (d * g) / 16;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int model_next(input int cur, input int tgt);
`ifdef TEAM06_VOL_RAMP_EN
        if (tgt > cur) return (cur + 8 < tgt) ? cur + 8 : tgt;
        else           return (cur - 8 > tgt) ? cur - 8 : tgt;
`else
        return tgt;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, int'(out_valid), m_valid);
        chk({tag, "_ch0"},   int'(out_data[7:0]), m_d0);
        chk({tag, "_ch1"},   int'(out_data[15:8]), m_d1);
        chk({tag, "_gain"},  int'(cur_gain), m_gain);
    endtask

    // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
    task automatic step(input string tag, input bit iv, input bit ordy,
                        input int vol, input bit en, input int d0, input int d1);
        bit acc;
        int old_gain;
        in_valid  = iv;
        out_ready = ordy;
        volume    = vol[3:0];
        enable    = en;
        in_data   = {d1[7:0], d0[7:0]};
        #1;
        chk({tag, "_in_ready"}, int'(in_ready), int'(m_valid == 0 || ordy));
        acc = iv && (m_valid == 0 || ordy);
        if (acc) begin
            old_gain = m_gain;
            m_d0     = scale(d0, old_gain);
            m_d1     = scale(d1, old_gain);
            m_valid  = 1;
            m_gain   = model_next(old_gain, en ? lut[vol] : 0);
        end else if (m_valid != 0 && ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
        $display("%s: acc=%0d gain=%0d out_valid=%0d out=%0d,%0d", tag, acc,
                 cur_gain, out_valid, out_data[7:0], out_data[15:8]);
    endtask

    // Asynchronous reset applied between clock edges, checked before the next edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        m_gain = 0; m_valid = 0; m_d0 = 0; m_d1 = 0;
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
        $display("%s: reset applied", tag);
    endtask

    initial begin
        int guard;
        #2;
        do_reset("reset");
        @(negedge clk);
        check_outputs("reset_idle");

        // Ramp up toward volume 10 (gain 128)
        for (int k = 0; k < 17; k++) step("ramp_up", 1, 1, 10, 1, 16, 16);
        chk("ramp_up_final_gain", int'(cur_gain), 128);
        step("ramp_drain", 0, 1, 10, 1, 0, 0);

        // Settle at 255, then a saturating frame
        guard = 0;
        while (m_gain != 255 && guard < 64) begin
            step("to_max", 1, 1, 15, 1, 16, 16);
            guard++;
        end
        chk("to_max_reached", int'(cur_gain), 255);
        step("sat", 1, 1, 15, 1, 200, 1);
        chk("sat_ch0_const", int'(out_data[7:0]), 255);
        chk("sat_ch1_const", int'(out_data[15:8]), 15);

        // Backpressure: five stalled cycles, then release
        for (int k = 0; k < 5; k++) step("stall", 1, 0, 15, 1, 10 + k, 20 + k);
        for (int k = 0; k < 4; k++) step("release", 1, 1, 15, 1, 30 + k, 40 + k);
        step("release_drain", 0, 1, 15, 1, 0, 0);

        // Move to gain 64, then mute, then re-enable at volume 4
        guard = 0;
        while (m_gain != 64 && guard < 64) begin
            step("to_64", 1, 1, 8, 1, 16, 16);
            guard++;
        end
        chk("to_64_reached", int'(cur_gain), 64);
        for (int k = 0; k < 8; k++) step("mute", 1, 1, 8, 0, 16, 16);
        chk("mute_gain_zero", int'(cur_gain), 0);
        step("muted_out", 1, 1, 8, 0, 16, 16);
        for (int k = 0; k < 4; k++) step("reenable", 1, 1, 4, 1, 16, 16);
        chk("reenable_gain", int'(cur_gain), 16);

        // Reset in the middle of a ramp with a valid output pending
        for (int k = 0; k < 3; k++) step("pre_rst", 1, 1, 0, 0, 16, 16);
        for (int k = 0; k < 5; k++) step("mid_ramp", 1, 0, 12, 1, 50, 60);
        step("mid_ramp_hold", 0, 0, 12, 1, 0, 0);
        do_reset("rst_mid");
        @(negedge clk);
        check_outputs("rst_mid_after");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 7) != 0),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
